// File: rtl/toy_bus_fetch_order_pkg.sv
// Shared types and defaults for the fetch order controller.
// The optional macro TOY_BUS_FETCH_ORDER_ERR_EN is consumed by toy_bus_fetch_order_ctrl.
package toy_bus_fetch_order_pkg;

   typedef enum logic {
      TGT_OUT0 = 1'b0,
      TGT_OUT1 = 1'b1
   } tgt_e;

   localparam int DEPTH_DEF   = 8;
   localparam int SEL_BIT_DEF = 28;

endpackage

// File: rtl/toy_bus_order_fifo.sv
// Order FIFO of target tags: registered count/pointers, no bypass (a pushed
// entry becomes visible at head no earlier than the following cycle).
module toy_bus_order_fifo
   import toy_bus_fetch_order_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  tgt_e                     push_tag,
   input  logic                     pop,
   output tgt_e                     head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   tgt_e            mem_r [DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic            push_ok_s;
   logic            pop_ok_s;

   // Guard against over/underflow even if the caller misbehaves.
   assign push_ok_s = push && (count_r != CNT_FULL);
   assign pop_ok_s  = pop  && (count_r != '0);

   // Pointer and occupancy registers; pointers wrap naturally (DEPTH is a power of two).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         unique case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Tag storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_tag;
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/toy_bus_fetch_order_ctrl.sv
// Keeps fetch acks from two targets in request issue order.
// Define TOY_BUS_FETCH_ORDER_ERR_EN to build the sticky unexpected-ack detector.
module toy_bus_fetch_order_ctrl
   import toy_bus_fetch_order_pkg::*;
#(
   parameter int DEPTH   = DEPTH_DEF,
   parameter int SEL_BIT = SEL_BIT_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_req_vld,
   output logic                     in_req_rdy,
   input  logic [31:0]              in_req_addr,
   output logic                     dn_req_vld,
   input  logic                     dn_req_rdy,
   input  logic                     out0_ack_vld,
   output logic                     out0_ack_rdy,
   input  logic                     out1_ack_vld,
   output logic                     out1_ack_rdy,
   output logic                     ack_vld,
   input  logic                     ack_rdy,
   output logic                     ack_sel,
   output logic [$clog2(DEPTH):0]   outstanding,
   output logic                     err_unexp_ack
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [CW-1:0] count_s;
   tgt_e          head_s;
   tgt_e          push_tag_s;
   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          pop_s;
   logic          unused_addr_s;

   // Reset forces the empty/not-full view so the requester sees a clean bus.
   assign full_s  = !rst && (count_s == CNT_FULL);
   assign empty_s = rst || (count_s == '0);

   assign dn_req_vld = in_req_vld && !full_s;
   assign in_req_rdy = dn_req_rdy && !full_s;
   assign push_s     = in_req_vld && in_req_rdy;
   assign push_tag_s = tgt_e'(in_req_addr[SEL_BIT]);
   assign unused_addr_s = ^in_req_addr;

   toy_bus_order_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push_s),
      .push_tag (push_tag_s),
      .pop      (pop_s),
      .head     (head_s),
      .count    (count_s)
   );

   // Steer the ack handshake to the target at the FIFO head only.
   always_comb begin
      ack_vld      = 1'b0;
      ack_sel      = 1'b0;
      out0_ack_rdy = 1'b0;
      out1_ack_rdy = 1'b0;
      if (empty_s) begin
         ack_vld = 1'b0;
      end else begin
         case (head_s)
            TGT_OUT0: begin
               ack_vld      = out0_ack_vld;
               out0_ack_rdy = ack_rdy;
               ack_sel      = 1'b0;
            end
            TGT_OUT1: begin
               ack_vld      = out1_ack_vld;
               out1_ack_rdy = ack_rdy;
               ack_sel      = 1'b1;
            end
            default: begin
               ack_vld = 1'b0;
            end
         endcase
      end
   end

   assign pop_s       = ack_vld && ack_rdy;
   assign outstanding = count_s;

`ifdef TOY_BUS_FETCH_ORDER_ERR_EN
   logic err_r;

   // Sticky flag: any target ack while nothing is outstanding.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_r <= 1'b0;
      end else if (empty_s && (out0_ack_vld || out1_ack_vld)) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign err_unexp_ack = err_r;
`else
   assign err_unexp_ack = 1'b0;
`endif

endmodule

// File: tb/tb_toy_bus_fetch_order_ctrl.sv
// Scoreboard bench: a queue-based model of issued tags predicts every output
// each cycle; acks are checked against the issue order.
module tb_toy_bus_fetch_order_ctrl;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_req_vld;
   logic          in_req_rdy;
   logic [31:0]   in_req_addr;
   logic          dn_req_vld;
   logic          dn_req_rdy;
   logic          out0_ack_vld;
   logic          out0_ack_rdy;
   logic          out1_ack_vld;
   logic          out1_ack_rdy;
   logic          ack_vld;
   logic          ack_rdy;
   logic          ack_sel;
   logic [CW-1:0] outstanding;
   logic          err_unexp_ack;

   int n_chk  = 0;
   int n_fail = 0;
   int n_acks = 0;

   bit   model_q[$];
   bit   model_err = 1'b0;
   bit   m_ne, m_h, m_full;
   logic e_vld, e_r0, e_r1, e_sel, e_rdy, e_dvld;

   toy_bus_fetch_order_ctrl #(.DEPTH(DEPTH), .SEL_BIT(28)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_req_vld    (in_req_vld),
      .in_req_rdy    (in_req_rdy),
      .in_req_addr   (in_req_addr),
      .dn_req_vld    (dn_req_vld),
      .dn_req_rdy    (dn_req_rdy),
      .out0_ack_vld  (out0_ack_vld),
      .out0_ack_rdy  (out0_ack_rdy),
      .out1_ack_vld  (out1_ack_vld),
      .out1_ack_rdy  (out1_ack_rdy),
      .ack_vld       (ack_vld),
      .ack_rdy       (ack_rdy),
      .ack_sel       (ack_sel),
      .outstanding   (outstanding),
      .err_unexp_ack (err_unexp_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic dr,
                        input logic o0, input logic o1, input logic ar);
      in_req_vld   = v;
      in_req_addr  = a;
      dn_req_rdy   = dr;
      out0_ack_vld = o0;
      out1_ack_vld = o1;
      ack_rdy      = ar;
   endtask

   // Monitor: predict from the issue-order queue, compare, then advance the model.
   always @(negedge clk) begin
      m_ne   = !rst && (model_q.size() != 0);
      m_h    = m_ne ? model_q[0] : 1'b0;
      m_full = !rst && (model_q.size() == DEPTH);
      e_vld  = m_ne ? (m_h ? out1_ack_vld : out0_ack_vld) : 1'b0;
      e_r0   = m_ne && !m_h && ack_rdy;
      e_r1   = m_ne && m_h && ack_rdy;
      e_sel  = m_ne && m_h;
      e_rdy  = dn_req_rdy && !m_full;
      e_dvld = in_req_vld && !m_full;
      chk("outstanding", 32'(outstanding), 32'(model_q.size()));
      chk("in_req_rdy", 32'(in_req_rdy), 32'(e_rdy));
      chk("dn_req_vld", 32'(dn_req_vld), 32'(e_dvld));
      chk("ack_vld", 32'(ack_vld), 32'(e_vld));
      chk("out0_ack_rdy", 32'(out0_ack_rdy), 32'(e_r0));
      chk("out1_ack_rdy", 32'(out1_ack_rdy), 32'(e_r1));
      chk("ack_sel", 32'(ack_sel), 32'(e_sel));
      chk("err_unexp_ack", 32'(err_unexp_ack), 32'(model_err));
`ifdef TOY_BUS_FETCH_ORDER_ERR_EN
      if (rst) model_err = 1'b0;
      else if (!m_ne && (out0_ack_vld || out1_ack_vld)) model_err = 1'b1;
`endif
      if (rst) begin
         model_q.delete();
      end else begin
         if (e_vld && ack_rdy) begin
            chk("ack_order", 32'(ack_sel), 32'(model_q[0]));
            void'(model_q.pop_front());
            n_acks++;
         end
         if (in_req_vld && e_rdy) begin
            model_q.push_back(in_req_addr[28]);
         end
      end
   end

   initial begin
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      step();
      rst = 1'b0;
      step();
      chk("reset_outstanding", 32'(outstanding), 32'd0);

      // Out-of-order target valid: tag 1 issued first must be acked first.
      drive(1'b1, 32'h1000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      step();
      chk("ooo_blocked_vld", 32'(ack_vld), 32'd0);
      chk("ooo_blocked_rdy0", 32'(out0_ack_rdy), 32'd0);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("ooo_second_sel", 32'(ack_sel), 32'd0);
      chk("ooo_second_rdy0", 32'(out0_ack_rdy), 32'd1);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      chk("ooo_drained", 32'(outstanding), 32'd0);

      // Fill to DEPTH, then confirm backpressure and release after one pop.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
         step();
      end
      drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("full_count", 32'(outstanding), 32'(DEPTH));
      chk("full_in_rdy", 32'(in_req_rdy), 32'd0);
      chk("full_dn_vld", 32'(dn_req_vld), 32'd0);
      step();
      drive(1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("full_no_bypass", 32'(in_req_rdy), 32'd0);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("after_pop_rdy", 32'(in_req_rdy), 32'd1);
      for (int i = 0; i < 30 && outstanding != 0; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
         step();
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("drain_timeout", 32'(outstanding), 32'd0);

      // Simultaneous push and pop at count 4.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h1000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
         step();
      end
      drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("push_pop_count", 32'(outstanding), 32'd4);

      // Random traffic exercising pointer wrap and ordering.
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         step();
      end
      for (int i = 0; i < 30 && outstanding != 0; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
         step();
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("rand_drain", 32'(outstanding), 32'd0);

      // Reset with 5 outstanding discards everything.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
         step();
      end
      drive(1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("rst_outstanding", 32'(outstanding), 32'd0);
      chk("rst_ack_vld", 32'(ack_vld), 32'd0);

      // Ack from out1 while empty: sticky error (only when the detector is built).
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef TOY_BUS_FETCH_ORDER_ERR_EN
      chk("err_set", 32'(err_unexp_ack), 32'd1);
`else
      chk("err_tied", 32'(err_unexp_ack), 32'd0);
`endif
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("err_cleared", 32'(err_unexp_ack), 32'd0);
      chk("acks_seen", 32'(n_acks > 10), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/toy_bus_fetch_order_ctrl.md
TOY_BUS_FETCH_ORDER_CTRL -- requirements
Module: toy_bus_fetch_order_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8: maximum outstanding fetch requests; power of two, at least 2.
REQ-002 The block SHALL have parameter SEL_BIT, default 28: address bit that selects the target (0 = out0, 1 = out1).
REQ-003 The block SHALL use one clock, clk (input, 1 bit); all state SHALL update on its rising edge.
REQ-004 The block SHALL have input rst, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have input in_req_vld, 1 bit: upstream fetch request valid.
REQ-006 The block SHALL have output in_req_rdy, 1 bit: upstream fetch request ready.
REQ-007 The block SHALL have input in_req_addr, 32 bits: upstream request address.
REQ-008 The block SHALL have output dn_req_vld, 1 bit: request valid towards the 2-way fetch decoder.
REQ-009 The block SHALL have input dn_req_rdy, 1 bit: decoder ready.
REQ-010 The block SHALL have, for each target k in {0, 1}: input outk_ack_vld, 1 bit; output outk_ack_rdy, 1 bit.
REQ-011 The block SHALL have output ack_vld, 1 bit; input ack_rdy, 1 bit: ordered ack towards the requester.
REQ-012 The block SHALL have output ack_sel, 1 bit: payload mux select for the ack data path.
REQ-013 The block SHALL have output outstanding, $clog2(DEPTH)+1 bits: current occupancy.
REQ-014 The block SHALL have output err_unexp_ack, 1 bit: sticky error flag.

Function
REQ-015 The block SHALL hold an order FIFO of DEPTH 1-bit target tags, plus a count, wr_ptr and rd_ptr; pointers SHALL wrap modulo DEPTH.
REQ-016 full SHALL be defined as count==DEPTH and empty as count==0.
REQ-017 dn_req_vld SHALL equal in_req_vld AND NOT full.
REQ-018 in_req_rdy SHALL equal dn_req_rdy AND NOT full.
REQ-019 Request valid/ready SHALL be combinational, with zero added latency.
REQ-020 A push SHALL occur when in_req_vld AND in_req_rdy; the pushed tag SHALL be in_req_addr[SEL_BIT].
REQ-021 When not empty, with head tag h: ack_vld SHALL equal outh_ack_vld; outh_ack_rdy SHALL equal ack_rdy; the non-head outk_ack_rdy SHALL be 0; ack_sel SHALL equal h.
REQ-022 When empty: ack_vld, out0_ack_rdy, out1_ack_rdy and ack_sel SHALL all be 0.
REQ-023 A pop SHALL occur when ack_vld AND ack_rdy.
REQ-024 On a simultaneous push and pop, count SHALL stay unchanged and both pointers SHALL advance.
REQ-025 There SHALL be no bypass: full blocks a push even when a pop occurs in the same cycle.
REQ-026 There SHALL be no bypass: an entry pushed in cycle N SHALL be poppable no earlier than cycle N+1.
REQ-027 outstanding SHALL equal the registered count.
REQ-028 No combinational path SHALL exist from any ack input to in_req_rdy or dn_req_vld.
REQ-029 Acks SHALL return to the requester strictly in request issue order, regardless of the order in which targets assert valid.

Reset
REQ-030 When rst is high at a clock edge, count, wr_ptr, rd_ptr and err_unexp_ack SHALL clear to 0.
REQ-031 FIFO tag contents need not be reset.
REQ-032 While rst is high, outputs SHALL follow the empty/not-full equations (in_req_rdy = dn_req_rdy).
REQ-033 A reset during traffic SHALL discard all outstanding entries; any in-flight acks arriving afterwards SHALL be treated per REQ-034/REQ-036.

Configuration
REQ-034 With TOY_BUS_FETCH_ORDER_ERR_EN defined, err_unexp_ack SHALL set at a clock edge when out0_ack_vld or out1_ack_vld is high while empty.
REQ-035 With TOY_BUS_FETCH_ORDER_ERR_EN defined, err_unexp_ack SHALL remain set until reset.
REQ-036 Without TOY_BUS_FETCH_ORDER_ERR_EN, err_unexp_ack SHALL be tied to 0 and no detection logic SHALL be built.

Structure
REQ-037 A shared package toy_bus_fetch_order_pkg SHALL hold the target tag type (1-bit enum TGT_OUT0/TGT_OUT1) and the DEPTH and SEL_BIT defaults.
REQ-038 The tag FIFO storage and pointers SHALL be one sub-module, toy_bus_order_fifo (push, pop, head, count; no bypass).

Verification
REQ-039 The bench SHALL cover: after rst, DEPTH=8 -> outstanding=0, ack_vld=0, both outk_ack_rdy=0, in_req_rdy=dn_req_rdy.
REQ-040 The bench SHALL cover: push addr 0x1000_0000 then 0x0000_0000 (tags 1, 0); out0_ack_vld asserted first -> ack_vld=0 and out0_ack_rdy=0 until out1 ack pops; then ack_sel=0 and out0 passes.
REQ-041 The bench SHALL cover: 8 pushes with no acks -> outstanding=8, in_req_rdy=0, dn_req_vld=0 even with dn_req_rdy=1; one pop -> in_req_rdy=1 the next cycle.
REQ-042 The bench SHALL cover: at count=4, push and pop in the same cycle -> outstanding stays 4; 20 cycles of random push/pop -> pointer wrap, with acks exactly in issue order.
REQ-043 The bench SHALL cover: rst asserted with 5 outstanding -> next cycle outstanding=0, ack_vld=0.
REQ-044 The bench SHALL cover: with TOY_BUS_FETCH_ORDER_ERR_EN, out1_ack_vld=1 while empty -> err_unexp_ack=1 next cycle and held until rst; without the macro it stays 0.
